// File: rtl/pc_branch_ctrl_if.sv
// Signal bundle between the PC/branch stage and its fetch/decode neighbours.
// Branch/halt/flag requests flow in; fetch address and control status flow out.
interface pc_branch_ctrl_if #(
    parameter int unsigned WIDTH = 16
);
    logic             stall;
    logic             br_valid;
    logic             br_reg;
    logic [2:0]       cond;
    logic [WIDTH-1:0] tgt_imm;
    logic [WIDTH-1:0] tgt_reg;
    logic             halt_dec;
    logic [2:0]       flag_wr;
    logic [2:0]       alu_flags;

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus2;
    logic             taken;
    logic             flush;
    logic             misalign;
    logic             halted;
    logic [2:0]       flags;

    modport master (
        output stall, br_valid, br_reg, cond, tgt_imm, tgt_reg, halt_dec, flag_wr, alu_flags,
        input  pc, pc_plus2, taken, flush, misalign, halted, flags
    );

    modport slave (
        input  stall, br_valid, br_reg, cond, tgt_imm, tgt_reg, halt_dec, flag_wr, alu_flags,
        output pc, pc_plus2, taken, flush, misalign, halted, flags
    );
endinterface

// File: rtl/pc_branch_ctrl.sv
// Program counter, Z/V/N flag register and branch resolution for the 16-bit pipeline.
// Redirects fetch on a taken branch, flushes the wrong-path slot for one cycle, and implements HLT.
module pc_branch_ctrl #(
    parameter int unsigned      WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    pc_branch_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_HALT     = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [2:0]       flags_q, flags_d;
    logic             misalign_q, misalign_d;

    logic             cond_true_c;
    logic             taken_c;
    logic [WIDTH-1:0] target_c;
    logic [WIDTH-1:0] pc_plus2_c;
    logic             flush_c;
    logic             halted_c;
    logic             z_c, v_c, n_c;

    assign z_c = flags_q[2];
    assign v_c = flags_q[1];
    assign n_c = flags_q[0];

    // Conditions look only at the registered flags, so a same-cycle write is not seen.
    always_comb begin
        cond_true_c = 1'b0;
        case (bus.cond)
            3'b000:  cond_true_c = ~z_c;
            3'b001:  cond_true_c = z_c;
            3'b010:  cond_true_c = ~z_c & ~n_c;
            3'b011:  cond_true_c = n_c;
            3'b100:  cond_true_c = z_c | ~n_c;
            3'b101:  cond_true_c = n_c | z_c;
            3'b110:  cond_true_c = v_c;
            default: cond_true_c = 1'b1;
        endcase
    end

    assign taken_c    = (state_q == ST_RUN) & bus.br_valid & ~bus.stall & cond_true_c;
    assign target_c   = bus.br_reg ? bus.tgt_reg : bus.tgt_imm;
    assign pc_plus2_c = pc_q + WIDTH'(2);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (bus.stall) begin
                    state_d = ST_RUN;
                end else if (bus.halt_dec) begin
                    state_d = ST_HALT;
                end else if (taken_c) begin
                    state_d = ST_REDIRECT;
                end
            end
            ST_REDIRECT: state_d = ST_RUN;
            ST_HALT:     state_d = ST_HALT;
            default:     state_d = ST_RUN;
        endcase
    end

    always_comb begin
        flush_c  = 1'b0;
        halted_c = 1'b0;
        case (state_q)
            ST_REDIRECT: flush_c  = 1'b1;
            ST_HALT:     halted_c = 1'b1;
            default: begin
                flush_c  = 1'b0;
                halted_c = 1'b0;
            end
        endcase
    end

    // PC and misalign next values; flags accept writes in every state.
    always_comb begin
        pc_d       = pc_q;
        misalign_d = 1'b0;
        flags_d    = (flags_q & ~bus.flag_wr) | (bus.alu_flags & bus.flag_wr);
        case (state_q)
            ST_RUN: begin
                if (!bus.stall && !bus.halt_dec) begin
                    if (taken_c) begin
                        pc_d       = {target_c[WIDTH-1:1], 1'b0};
                        misalign_d = target_c[0];
                    end else begin
                        pc_d = pc_plus2_c;
                    end
                end
            end
            ST_REDIRECT: begin
                if (!bus.stall) begin
                    pc_d = pc_plus2_c;
                end
            end
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            flags_q    <= 3'b000;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            flags_q    <= flags_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_plus2 = pc_plus2_c;
    assign bus.taken    = taken_c;
    assign bus.flush    = flush_c;
    assign bus.misalign = misalign_q;
    assign bus.halted   = halted_c;
    assign bus.flags    = flags_q;

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Bench for pc_branch_ctrl: directed vectors, a cycle-level reference model checked every
// cycle on the falling edge, and hand-computed literal expectations along the way.
module tb_pc_branch_ctrl;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    pc_branch_ctrl_if #(.WIDTH(16)) bus ();

    pc_branch_ctrl #(
        .WIDTH    (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: where fetch is, whether the wrong-path slot is live, whether halted.
    logic [15:0] m_pc;
    logic [2:0]  m_flags;
    logic        m_redirect;
    logic        m_halted;
    logic        m_mis;
    logic        m_valid;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_valid = 1'b0;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic cond_holds(input logic [2:0] c, input logic [2:0] f);
        logic z, v, n;
        z = f[2];
        v = f[1];
        n = f[0];
        case (c)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !z && !n;
            3'd3:    return n;
            3'd4:    return z || (!z && !n);
            3'd5:    return n || z;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic model_taken();
        return !m_halted && !m_redirect && bus.br_valid && !bus.stall &&
               cond_holds(bus.cond, m_flags);
    endfunction

    function automatic logic [15:0] branch_target();
        return bus.br_reg ? bus.tgt_reg : bus.tgt_imm;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pc       <= 16'h0000;
            m_flags    <= 3'b000;
            m_redirect <= 1'b0;
            m_halted   <= 1'b0;
            m_mis      <= 1'b0;
            m_valid    <= 1'b1;
        end else begin
            m_flags    <= (m_flags & ~bus.flag_wr) | (bus.alu_flags & bus.flag_wr);
            m_mis      <= 1'b0;
            m_redirect <= 1'b0;
            if (m_halted) begin
                m_halted <= 1'b1;
            end else if (m_redirect) begin
                if (!bus.stall) m_pc <= m_pc + 16'd2;
            end else if (bus.stall) begin
                m_pc <= m_pc;
            end else if (bus.halt_dec) begin
                m_halted <= 1'b1;
            end else if (model_taken()) begin
                m_pc       <= branch_target() & 16'hFFFE;
                m_mis      <= branch_target() & 16'h0001 ? 1'b1 : 1'b0;
                m_redirect <= 1'b1;
            end else begin
                m_pc <= m_pc + 16'd2;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("pc",       bus.pc,                  m_pc);
            check("pc_plus2", bus.pc_plus2,            16'(m_pc + 16'd2));
            check("taken",    16'(bus.taken),          16'(model_taken()));
            check("flush",    16'(bus.flush),          16'(m_redirect));
            check("misalign", 16'(bus.misalign),       16'(m_mis));
            check("halted",   16'(bus.halted),         16'(m_halted));
            check("flags",    16'(bus.flags),          16'(m_flags));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall     = 1'b0;
        bus.br_valid  = 1'b0;
        bus.br_reg    = 1'b0;
        bus.cond      = 3'b000;
        bus.tgt_imm   = 16'h0000;
        bus.tgt_reg   = 16'h0000;
        bus.halt_dec  = 1'b0;
        bus.flag_wr   = 3'b000;
        bus.alu_flags = 3'b000;
    endtask

    task automatic br(input logic is_reg, input logic [2:0] c, input logic [15:0] timm,
                      input logic [15:0] treg);
        bus.br_valid = 1'b1;
        bus.br_reg   = is_reg;
        bus.cond     = c;
        bus.tgt_imm  = timm;
        bus.tgt_reg  = treg;
    endtask

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        check("rst_pc",     bus.pc,              16'h0000);
        check("rst_flush",  16'(bus.flush),      16'h0000);
        check("rst_halted", 16'(bus.halted),     16'h0000);
        check("rst_flags",  16'(bus.flags),      16'h0000);
        rst_n = 1'b1;

        // Free-running fetch.
        tick(); check("run_pc1", bus.pc, 16'h0002);
        tick(); check("run_pc2", bus.pc, 16'h0004);
        tick(); check("run_pc3", bus.pc, 16'h0006);
        check("run_flush", 16'(bus.flush), 16'h0000);

        // Set Z, then B EQ taken at 0010.
        bus.flag_wr = 3'b100; bus.alu_flags = 3'b100;
        tick(); idle();
        check("z_set_pc",    bus.pc,         16'h0008);
        check("z_set_flags", 16'(bus.flags), 16'h0004);
        repeat (4) tick();
        check("at_0010", bus.pc, 16'h0010);
        br(1'b0, 3'b001, 16'h0040, 16'h0000);
        #1 check("beq_taken", 16'(bus.taken), 16'h0001);
        tick(); idle();
        check("beq_pc",    bus.pc,         16'h0040);
        check("beq_flush", 16'(bus.flush), 16'h0001);
        tick();
        check("beq_pc2",    bus.pc,         16'h0042);
        check("beq_flush2", 16'(bus.flush), 16'h0000);

        // NE with Z=1 falls through; BR always to odd target.
        br(1'b0, 3'b000, 16'h0100, 16'h0000);
        #1 check("bne_taken", 16'(bus.taken), 16'h0000);
        tick(); idle();
        check("bne_pc", bus.pc, 16'h0044);
        br(1'b1, 3'b111, 16'h0000, 16'h1235);
        #1 check("br_taken", 16'(bus.taken), 16'h0001);
        tick(); idle();
        check("br_pc",  bus.pc,            16'h1234);
        check("br_mis", 16'(bus.misalign), 16'h0001);
        tick();
        check("br_pc2",  bus.pc,            16'h1236);
        check("br_mis2", 16'(bus.misalign), 16'h0000);

        // Clear Z; branch in the same cycle as the Z write sees the old value.
        bus.flag_wr = 3'b100; bus.alu_flags = 3'b000;
        tick(); idle();
        check("z_clr_pc",    bus.pc,         16'h1238);
        check("z_clr_flags", 16'(bus.flags), 16'h0000);
        br(1'b0, 3'b001, 16'h0200, 16'h0000);
        bus.flag_wr = 3'b100; bus.alu_flags = 3'b100;
        #1 check("old_z_taken", 16'(bus.taken), 16'h0000);
        tick(); idle();
        check("old_z_pc",    bus.pc,         16'h123A);
        check("old_z_flags", 16'(bus.flags), 16'h0004);
        br(1'b0, 3'b001, 16'h0200, 16'h0000);
        #1 check("new_z_taken", 16'(bus.taken), 16'h0001);
        tick(); idle();
        check("new_z_pc", bus.pc, 16'h0200);
        tick();
        check("new_z_pc2", bus.pc, 16'h0202);

        // Stall holds a pending branch for two cycles.
        br(1'b0, 3'b111, 16'h0300, 16'h0000);
        bus.stall = 1'b1;
        #1 check("stall_taken", 16'(bus.taken), 16'h0000);
        tick(); check("stall_pc1", bus.pc, 16'h0202);
        tick(); check("stall_pc2", bus.pc, 16'h0202);
        bus.stall = 1'b0;
        #1 check("unstall_taken", 16'(bus.taken), 16'h0001);
        tick(); idle();
        check("unstall_pc",    bus.pc,         16'h0300);
        check("unstall_flush", 16'(bus.flush), 16'h0001);
        tick(); check("unstall_pc2", bus.pc, 16'h0302);

        // A branch in the wrong-path slot is ignored.
        br(1'b0, 3'b111, 16'h0400, 16'h0000);
        tick();
        check("wp_pc", bus.pc, 16'h0400);
        br(1'b0, 3'b111, 16'h0500, 16'h0000);
        #1 check("wp_taken", 16'(bus.taken), 16'h0000);
        tick(); idle();
        check("wp_pc2",   bus.pc,         16'h0402);
        check("wp_flush", 16'(bus.flush), 16'h0000);

        // Stall during the redirect cycle holds pc but still ends the flush.
        br(1'b0, 3'b111, 16'h0600, 16'h0000);
        tick(); idle();
        bus.stall = 1'b1;
        tick();
        check("rdst_pc",    bus.pc,         16'h0600);
        check("rdst_flush", 16'(bus.flush), 16'h0000);
        bus.stall = 1'b0;
        tick();
        check("rdst_pc2", bus.pc, 16'h0602);

        // Every condition code against every flag combination.
        for (int f = 0; f < 8; f++) begin
            bus.flag_wr = 3'b111; bus.alu_flags = 3'(f);
            tick(); idle();
            for (int c = 0; c < 8; c++) begin
                br(1'b0, 3'(c), 16'h0800 | 16'(c << 4) | 16'(f & 1), 16'h0000);
                #1;
                if (f == 0 && c == 2) check("gt_clear", 16'(bus.taken), 16'h0001);
                if (f == 1 && c == 5) check("le_neg",   16'(bus.taken), 16'h0001);
                if (f == 4 && c == 2) check("gt_zero",  16'(bus.taken), 16'h0000);
                if (f == 2 && c == 6) check("ov_set",   16'(bus.taken), 16'h0001);
                tick(); idle();
                tick();
            end
        end

        // Reach 0020 and halt there; flags still writable while halted.
        br(1'b0, 3'b111, 16'h001E, 16'h0000);
        tick(); idle();
        check("to_001e", bus.pc, 16'h001E);
        tick();
        check("at_0020", bus.pc, 16'h0020);
        bus.halt_dec = 1'b1;
        br(1'b0, 3'b000, 16'h0700, 16'h0000);
        tick(); idle();
        check("hlt_pc",     bus.pc,          16'h0020);
        check("hlt_halted", 16'(bus.halted), 16'h0001);
        for (int k = 0; k < 4; k++) begin
            br(1'b0, 3'b111, 16'h0700, 16'h0000);
            bus.halt_dec = 1'(k & 1);
            #1 check("hlt_taken", 16'(bus.taken), 16'h0000);
            tick();
            check("hlt_hold_pc", bus.pc, 16'h0020);
        end
        idle();
        bus.flag_wr = 3'b111; bus.alu_flags = 3'b010;
        tick(); idle();
        check("hlt_flags",  16'(bus.flags),  16'h0002);
        check("hlt_still",  16'(bus.halted), 16'h0001);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst2_pc",     bus.pc,          16'h0000);
        check("rst2_halted", 16'(bus.halted), 16'h0000);
        check("rst2_flags",  16'(bus.flags),  16'h0000);

        // Wrap-around at the top of the address space.
        br(1'b0, 3'b111, 16'hFFFC, 16'h0000);
        tick(); idle();
        check("wrap_fffc", bus.pc, 16'hFFFC);
        tick();
        check("wrap_fffe",  bus.pc,       16'hFFFE);
        check("wrap_plus2", bus.pc_plus2, 16'h0000);
        tick();
        check("wrap_0000", bus.pc, 16'h0000);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_branch_ctrl.md
Name: pc_branch_ctrl

Overview:
- Program-counter and branch-resolution stage. Owns the PC register and the Z/V/N flag register.
- Drives pc_plus2 into the branch-target adder's A input and consumes the adder's Sum as the B-type target.
- Decides taken/not-taken from the condition code and registered flags, redirects fetch, and emits a one-cycle flush for the wrong-path instruction.
- Sits between fetch and decode of the 16-bit pipeline; also implements HLT.

Parameters:
- WIDTH, 16, datapath/PC width in bits.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- stall  input  1  hazard stall from decode; freezes PC and state
- br_valid  input  1  decode holds a branch (B or BR) this cycle
- br_reg  input  1  1 = BR (register target), 0 = B (adder target)
- cond  input  3  branch condition code
- tgt_imm  input  WIDTH  Sum output of branch-target adder
- tgt_reg  input  WIDTH  rs register value for BR
- halt_dec  input  1  decode holds HLT
- flag_wr  input  3  per-flag write enables {Z,V,N}
- alu_flags  input  3  new flag values {Z,V,N}
- pc  output  WIDTH  current fetch address
- pc_plus2  output  WIDTH  pc + 2, wraps mod 2^WIDTH; feeds adder A and link path
- taken  output  1  combinational: resolved branch is taken this cycle
- flush  output  1  registered: squash instruction in IF/ID
- misalign  output  1  registered one-cycle pulse: taken target had bit0 = 1
- halted  output  1  processor halted
- flags  output  3  registered {Z,V,N}

Behaviour:
- Reset (rst_n low at posedge, any state):
  - pc = RESET_PC, flags = 0, flush = 0, misalign = 0, halted = 0.
  - State = RUN. Reset overrides stall, branch and halt.
- States:
  - RUN: normal fetch.
  - REDIRECT: exactly one cycle after a taken branch.
  - HALT: terminal until reset.
- Condition evaluation uses registered flags only:
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 and N=0
  - 011 LT: N=1
  - 100 GE: Z=1 or (Z=0 and N=0)
  - 101 LE: N=1 or Z=1
  - 110 OV: V=1
  - 111 always
- taken = (state == RUN) and br_valid and not stall and cond_true.
- Target selection:
  - Target = tgt_reg if br_reg, else tgt_imm.
  - Bit0 of the target is forced to 0 before loading pc.
  - misalign pulses the next cycle if the raw target bit0 was 1.
- RUN transitions (priority order):
  - stall: pc holds, state holds, flags still update.
  - halt_dec: pc holds, go to HALT, halted = 1 from the next cycle. halt_dec beats br_valid.
  - taken: pc <= target, go to REDIRECT, flush = 1 during REDIRECT.
  - otherwise: pc <= pc_plus2.
- REDIRECT:
  - Lasts exactly one cycle regardless of stall.
  - br_valid and halt_dec are ignored; that instruction is wrong-path.
  - pc <= pc_plus2 unless stall is high, in which case pc holds.
  - Returns to RUN; flush = 0 afterward.
- HALT:
  - pc frozen; taken = 0, flush = 0.
  - halted stays 1; flags still accept writes.
- Flag register:
  - Each bit is written independently when its flag_wr bit is 1; writes are visible to cond the next cycle.
  - A simultaneous write and branch evaluates the old value.
- Wrap-around: pc_plus2 at 16'hFFFE gives 16'h0000. No error is raised; the adder's Ovfl is not consumed here.

Test Plan:
- Reset then 3 free-running cycles, no stall → pc sequence 0000, 0002, 0004, 0006; flush=0, halted=0.
- flags Z=1; at pc=0010, B EQ with tgt_imm=0040 → taken=1; next cycle pc=0040, flush=1; following cycle pc=0042, flush=0.
- Branch NE with Z=1 → taken=0, pc advances by 2. BR always with tgt_reg=1235 → pc=1234, misalign pulse 1 cycle.
- flag_wr=100 with alu_flags Z=1 in the same cycle as B EQ (old Z=0) → not taken; a branch one cycle later is taken.
- stall held 2 cycles with br_valid and cond=111 → pc unchanged, taken=0. Release stall → branch resolves taken.
- halt_dec at pc=0020 → pc stays 0020, halted=1 indefinitely. rst_n low mid-halt → pc=0000, halted=0 next cycle. pc=FFFE without branch → next pc=0000.
